// File: rtl/game_pkg.sv
// Shared game-wide constants and types used by the obstacle generator and
// the collision checker.
package game_pkg;

    localparam int NUM_OBSTACLES = 10;
    localparam int SCREEN_WIDTH  = 640;

    // Vertical limits of the play field used when obstacles are generated.
    localparam logic [8:0] UPPER_BOUND = 9'd40;
    localparam logic [8:0] LOWER_BOUND = 9'd440;

    // Coordinates of an unused slot; such a slot never collides.
    localparam logic [9:0] OFFSCREEN_X = 10'd700;
    localparam logic [8:0] OFFSCREEN_Y = 9'd500;

    typedef enum logic [1:0] {
        GM_IDLE   = 2'b00,
        GM_RUN    = 2'b01,
        GM_FREEZE = 2'b10
    } gamemode_t;

    // Right and bottom edges are exclusive.
    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
    } box_t;

    // The generator's slot encoding {left,right} / {top,bottom} maps
    // directly onto box_t field order.
    function automatic box_t make_box(input logic [19:0] x, input logic [17:0] y);
        return box_t'({x, y});
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned overlap test between one obstacle box and the player
// box; touching edges do not count.
module box_overlap
    import game_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_WIDTH
) (
    input  box_t obs,
    input  box_t player,
    output logic overlap
);

    localparam logic [9:0] SCREEN_EDGE = 10'(SCREEN_W);

    logic [10:0] p_right;
    logic [9:0]  p_bottom;
    logic        skip;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        // The player's far edges arrive modulo field width; a far edge that
        // ended up below its near edge wrapped, so restore the carry bit.
        p_right  = {player.x1 < player.x0, player.x1};
        p_bottom = {player.y1 < player.y0, player.y1};
        skip     = (obs.x0 >= SCREEN_EDGE) || (obs.x1 <= obs.x0);
        overlap  = !skip
                && (player.x0 < obs.x1)
                && ({1'b0, obs.x0} < p_right)
                && (player.y0 < obs.y1)
                && ({1'b0, obs.y0} < p_bottom);
    end

endmodule

// File: rtl/collision_detect.sv
// Per-frame collision checker: snapshots obstacle and player boxes, scans one
// slot per clock through a single shared comparator, and reports the result.
module collision_detect
    import game_pkg::*;
#(
    parameter int NUM_OBS  = NUM_OBSTACLES,
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 20,
    parameter int SCREEN_W = SCREEN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic [1:0]                 gamemode,
    input  logic [NUM_OBS-1:0][19:0]   obstacle_x,
    input  logic [NUM_OBS-1:0][17:0]   obstacle_y,
    input  logic [9:0]                 player_x,
    input  logic [8:0]                 player_y,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic [3:0]                 hit_idx,
    output logic [3:0]                 hit_count,
    output logic                       crash,
    output logic                       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_OBS - 1);
    localparam logic [9:0] PW       = 10'(PLAYER_W);
    localparam logic [8:0] PH       = 9'(PLAYER_H);

    state_t     state, state_nxt;
    gamemode_t  gm;
    logic       start_ok;
    logic       last;

    logic [NUM_OBS-1:0][19:0] snap_x;
    logic [NUM_OBS-1:0][17:0] snap_y;
    logic [9:0]               snap_px;
    logic [8:0]               snap_py;

    logic [3:0] idx;
    logic [3:0] count;
    logic [3:0] first_idx;
    logic       found;

    box_t       obs_box, player_box;
    logic       slot_hit;
    logic       scan_found;
    logic [3:0] scan_first;
    logic [3:0] scan_count;

    assign gm       = gamemode_t'(gamemode);
    assign start_ok = frame_start && (gm == GM_RUN);
    assign last     = (idx == LAST_IDX);

    assign obs_box    = make_box(snap_x[idx], snap_y[idx]);
    assign player_box = '{x0: snap_px, x1: snap_px + PW, y0: snap_py, y1: snap_py + PH};

    box_overlap #(.SCREEN_W(SCREEN_W)) u_overlap (
        .obs     (obs_box),
        .player  (player_box),
        .overlap (slot_hit)
    );

    // Running totals including the slot evaluated this cycle.
    assign scan_found = found | slot_hit;
    assign scan_first = found ? first_idx : idx;
    assign scan_count = count + {3'b000, slot_hit};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        overrun   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                busy    = 1'b1;
                overrun = frame_start;
                if (last) state_nxt = ST_REPORT;
            end
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the snapshot bank is reset explicitly so a scan never sees power-up garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_x  <= '0;
            snap_y  <= '0;
            snap_px <= '0;
            snap_py <= '0;
        end else if (state == ST_IDLE && start_ok) begin
            snap_x  <= obstacle_x;
            snap_y  <= obstacle_y;
            snap_px <= player_x;
            snap_py <= player_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            count     <= '0;
            first_idx <= '0;
            found     <= 1'b0;
        end else if (state == ST_IDLE && start_ok) begin
            idx       <= '0;
            count     <= '0;
            first_idx <= '0;
            found     <= 1'b0;
        end else if (state == ST_SCAN) begin
            idx       <= idx + 4'd1;
            count     <= scan_count;
            found     <= scan_found;
            if (slot_hit && !found) first_idx <= idx;
        end
    end

    // Results latch on the edge that enters REPORT and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            hit_count <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_SCAN && last) begin
                done      <= 1'b1;
                hit       <= scan_found;
                hit_idx   <= scan_found ? scan_first : 4'd0;
                hit_count <= scan_count;
            end
        end
    end

    // Idle mode clears the crash flag and wins over a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crash <= 1'b0;
        else if (gm == GM_IDLE)
            crash <= 1'b0;
        else if (state == ST_SCAN && last && scan_found)
            crash <= 1'b1;
    end

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect: expected reports are queued when a
// frame is started and a monitor pops and compares each done pulse.
module tb_collision_detect;
    import game_pkg::*;

    localparam int N = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 frame_start = 1'b0;
    logic [1:0]           gamemode = 2'b00;
    logic [N-1:0][19:0]   obstacle_x;
    logic [N-1:0][17:0]   obstacle_y;
    logic [9:0]           player_x = '0;
    logic [8:0]           player_y = '0;
    logic                 busy, done, hit, crash, overrun;
    logic [3:0]           hit_idx, hit_count;

    collision_detect #(
        .NUM_OBS(N), .PLAYER_W(20), .PLAYER_H(20), .SCREEN_W(640)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .gamemode    (gamemode),
        .obstacle_x  (obstacle_x),
        .obstacle_y  (obstacle_y),
        .player_x    (player_x),
        .player_y    (player_y),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .hit_count   (hit_count),
        .crash       (crash),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        int         cyc;
        int         hit;
        int         idx;
        int         cnt;
        int         crash;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int b, input int d, input int h,
                             input int hi, input int hc, input int c, input int o);
        check({name, "_busy"},      int'(busy),      b);
        check({name, "_done"},      int'(done),      d);
        check({name, "_hit"},       int'(hit),       h);
        check({name, "_hit_idx"},   int'(hit_idx),   hi);
        check({name, "_hit_count"}, int'(hit_count), hc);
        check({name, "_crash"},     int'(crash),     c);
        check({name, "_overrun"},   int'(overrun),   o);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_done_cycle"}, cyc,             mon_e.cyc);
                check({mon_e.name, "_hit"},        int'(hit),       mon_e.hit);
                check({mon_e.name, "_hit_idx"},    int'(hit_idx),   mon_e.idx);
                check({mon_e.name, "_hit_count"},  int'(hit_count), mon_e.cnt);
                check({mon_e.name, "_crash"},      int'(crash),     mon_e.crash);
            end
        end
    end

    task automatic set_all_off();
        for (int i = 0; i < N; i++) begin
            obstacle_x[i] = {OFFSCREEN_X, OFFSCREEN_X};
            obstacle_y[i] = {OFFSCREEN_Y, OFFSCREEN_Y};
        end
    endtask

    task automatic set_slot(input int i, input int l, input int r, input int t, input int b);
        obstacle_x[i] = {10'(l), 10'(r)};
        obstacle_y[i] = {9'(t), 9'(b)};
    endtask

    task automatic push_exp(input string name, input int h, input int hi, input int hc, input int c);
        exp_t e;
        e.name  = name;
        e.cyc   = cyc + 11;
        e.hit   = h;
        e.idx   = hi;
        e.cnt   = hc;
        e.crash = c;
        sb.push_back(e);
    endtask

    task automatic start_frame(input string name, input int h, input int hi, input int hc, input int c);
        @(posedge clk); #1;
        frame_start = 1'b1;
        push_exp(name, h, hi, hc, c);
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done for %s expected done by cycle %0d",
                     sb[0].name, sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic set_mode(input gamemode_t m);
        @(posedge clk); #1;
        gamemode = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_all_off();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic hit on slot 3.
        gamemode = GM_RUN;
        player_x = 10'd100;
        player_y = 9'd200;
        set_slot(3, 90, 130, 190, 260);
        start_frame("t1_basic", 1, 3, 1, 1);
        wait_done();

        // Clear crash, then frame where every candidate only touches an edge.
        set_mode(GM_IDLE);
        @(posedge clk);
        @(negedge clk);
        check("t2_crash_cleared", int'(crash), 0);
        set_mode(GM_RUN);
        set_all_off();
        set_slot(0, 120, 160, 190, 260);
        set_slot(1, 90, 130, 220, 260);
        set_slot(2, 90, 130, 150, 200);
        set_slot(4, 60, 100, 190, 260);
        start_frame("t2_touch", 0, 0, 0, 0);
        wait_done();
        set_slot(0, 119, 160, 190, 260);
        start_frame("t2_shift", 1, 0, 1, 1);
        wait_done();

        // Several hits: first index reported, all counted; then idle clears crash.
        set_all_off();
        set_slot(2, 90, 130, 190, 260);
        set_slot(5, 90, 130, 190, 260);
        set_slot(7, 90, 130, 190, 260);
        start_frame("t3_multi", 1, 2, 3, 1);
        wait_done();
        set_mode(GM_IDLE);
        @(posedge clk);
        @(negedge clk);
        check("t3_crash_cleared", int'(crash), 0);
        check("t3_hit_held", int'(hit), 1);
        check("t3_idx_held", int'(hit_idx), 2);
        check("t3_count_held", int'(hit_count), 3);

        // Overrun during scan and input changes after the snapshot.
        set_mode(GM_RUN);
        set_all_off();
        set_slot(3, 90, 130, 190, 260);
        @(posedge clk); #1;
        frame_start = 1'b1;
        push_exp("t4_overrun", 1, 3, 1, 1);
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        set_all_off();
        player_x = 10'd500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(negedge clk);
        check("t4_overrun_pulse", int'(overrun), 1);
        check("t4_busy", int'(busy), 1);
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("t4_overrun_clear", int'(overrun), 0);
        wait_done();
        repeat (15) @(negedge clk);

        // Off-screen markers, degenerate boxes, right screen edge, no wrap.
        player_x = 10'd300;
        player_y = 9'd100;
        set_all_off();
        start_frame("t6_offscreen", 0, 0, 0, 1);
        wait_done();
        player_x = 10'd100;
        player_y = 9'd200;
        set_slot(4, 110, 105, 190, 260);
        start_frame("t6_degenerate", 0, 0, 0, 1);
        wait_done();
        player_x = 10'd630;
        player_y = 9'd100;
        set_all_off();
        set_slot(0, 640, 700, 90, 130);
        set_slot(1, 639, 700, 90, 130);
        start_frame("t6_screen_edge", 1, 1, 1, 1);
        wait_done();
        player_x = 10'd1010;
        player_y = 9'd500;
        set_all_off();
        set_slot(6, 600, 1020, 505, 510);
        start_frame("t6_no_wrap", 1, 6, 1, 1);
        wait_done();

        // Idle mode entered mid-scan: scan completes but crash stays clear.
        set_mode(GM_IDLE);
        set_mode(GM_RUN);
        player_x = 10'd100;
        player_y = 9'd200;
        set_all_off();
        set_slot(3, 90, 130, 190, 260);
        start_frame("t7_idle_mid", 1, 3, 1, 0);
        set_mode(GM_IDLE);
        wait_done();

        // Frozen mode ignores frame_start and holds outputs.
        set_mode(GM_FREEZE);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("t5_freeze_busy", int'(busy), 0);
        repeat (14) @(negedge clk);
        check_out("t5_freeze_held", 0, 0, 1, 3, 1, 0, 0);

        // Reset in the middle of a scan.
        set_mode(GM_RUN);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("t5_scan_busy", int'(busy), 1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_out("t5_reset", 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_out("t5_after_reset", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
